instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction-fetch stage of the pipelined MIPS core; consumer of the program counter produced by the PC control block. Presents the PC to a synchronous instruction memory, aligns the returned word with its PC in an IF/ID output register, and honours stall and flush (jump) consistently with the PC update rules. It detects the HALT instruction and drives the sticky halt flag fed back to PC control.

## Interface
- `HALT_WORD`, default 32'hFFFF_FFFF: instruction encoding treated as HALT.
- `i_clk`  in  1  system clock; all state updates on rising edge.
- `i_reset`  in  1  asynchronous, active-low reset.
- `i_pc`  in  32  current PC from PC control.
- `i_stall`  in  1  hazard stall; freezes the stage.
- `i_flush`  in  1  jump taken this cycle; kills wrong-path fetches.
- `o_imem_addr`  out  32  instruction memory address (= `i_pc`).
- `o_imem_en`  out  1  memory read enable.
- `i_imem_data`  in  32  memory read data, valid the cycle after an enabled read.
- `o_instr`  out  32  IF/ID instruction.
- `o_pc_plus4`  out  32  IF/ID PC+4 of `o_instr`.
- `o_valid`  out  1  IF/ID contents are a real instruction (0 = bubble).
- `o_halt`  out  1  sticky: a HALT word has been fetched; drives PC control halt.

## Operation
- State: fetch slot F (`f_valid`, `f_pc`), skid (`s_valid`, `s_data`), IF/ID register D (`o_valid`, `o_instr`, `o_pc_plus4`), `halt_seen`.
- `o_imem_addr = i_pc`; `o_imem_en = !i_stall && !halt_seen`, combinational.
- Advance (edge with `i_stall`=0):
  - if `i_flush`: `f_valid`<=0, `o_valid`<=0, `s_valid`<=0; `o_instr`/`o_pc_plus4` don't-care.
  - else: D <= {`f_valid && !halt_seen`, `s_valid ? s_data : i_imem_data`, `f_pc + 4`}; F <= {`!halt_seen`, `i_pc`}; `s_valid`<=0.
  - `halt_seen`<=1 when the word loaded into D is valid and equals `HALT_WORD`.
- Stall (edge with `i_stall`=1): F, D, `halt_seen` hold; `i_flush` ignored (matches PC control, where stall blocks jump). If `f_valid && !s_valid`: `s_data`<=`i_imem_data`, `s_valid`<=1 (memory output not guaranteed to hold while disabled).
- After `halt_seen`: no further reads, all subsequent D loads invalid; only reset clears it.
- Arithmetic: `f_pc + 4` modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000).

## Timing
- Reset (asynchronous, `i_reset`=0): `f_valid`=0, `s_valid`=0, `o_valid`=0, `o_instr`=0, `o_pc_plus4`=0, `o_halt`=0; `o_imem_en` = `!i_stall` immediately after release.
- Latency: PC P presented in cycle n (no stall/flush) -> `o_instr`=mem[P], `o_pc_plus4`=P+4, `o_valid`=1 in cycle n+2. Throughput 1 instr/cycle.
- Flush in cycle n (no stall): F and D bubbles in n+1; target T appears on `i_pc` in n+1, valid at output in n+3 (2 bubbles).
- Stall of k cycles: outputs frozen k cycles; the instruction in F emerges exactly once, unduplicated and unlost, on the first advance after release.
- `o_halt` = `halt_seen`; rises in the same cycle `o_valid`=1 with `o_instr`=`HALT_WORD`.
- Reset asserted mid-stall or mid-flush: all state cleared immediately; skid contents discarded.

## Test plan
- Reset then straight-line run, mem[i]=0x1000_0000+i, PC 0,4,8.. -> from cycle 2: `o_valid`=1, `o_instr`=0x1000_0000,0x1000_0001..., `o_pc_plus4`=4,8,....
- Jump: flush while F holds PC 8, D holds PC 4, target 0x40 -> next two cycles `o_valid`=0, then `o_instr`=mem[0x40], `o_pc_plus4`=0x44; words from 8/12 never valid.
- Stall 3 cycles with F=PC 12, memory driving garbage while disabled -> D frozen for 3 cycles, then `o_instr`=mem[12] once, followed by mem[16].
- Stall and flush together for 2 cycles -> flush ignored, state held; after release, flow resumes with no bubbles.
- HALT_WORD at PC 0x20 -> `o_halt`=1 in cycle `o_instr`=0xFFFF_FFFF; `o_imem_en`=0 and `o_valid`=0 thereafter until reset.
- Async reset asserted mid-cycle during a stall with `s_valid`=1 -> all outputs 0 immediately; after release, first valid output is mem[`i_pc`] two cycles later.

Source files
------------

// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - synchronous instruction memory read port
interface instr_fetch_if;
  logic [31:0] imem_addr;
  logic        imem_en;
  logic [31:0] imem_data;

  modport master (output imem_addr, output imem_en, input imem_data);
  modport slave  (input imem_addr, input imem_en, output imem_data);
endinterface

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - IF stage: PC to imem, IF/ID register, stall skid, flush, sticky HALT
module instr_fetch #(
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [31:0]          i_pc,
  input  logic                 i_stall,
  input  logic                 i_flush,
  instr_fetch_if.master        imem,
  output logic [31:0]          o_instr,
  output logic [31:0]          o_pc_plus4,
  output logic                 o_valid,
  output logic                 o_halt
);

  logic        f_valid;
  logic [31:0] f_pc;
  logic        s_valid;
  logic [31:0] s_data;
  logic        halt_seen;
  logic [31:0] d_word;
  logic        d_load_valid;

  assign imem.imem_addr = i_pc;
  assign imem.imem_en   = !i_stall && !halt_seen;
  assign o_halt         = halt_seen;

  // Memory output is not held while disabled, so a stalled fetch reads from the skid.
  assign d_word       = s_valid ? s_data : imem.imem_data;
  assign d_load_valid = f_valid && !halt_seen;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      f_valid    <= 1'b0;
      f_pc       <= 32'd0;
      s_valid    <= 1'b0;
      s_data     <= 32'd0;
      o_valid    <= 1'b0;
      o_instr    <= 32'd0;
      o_pc_plus4 <= 32'd0;
      halt_seen  <= 1'b0;
    end else if (!i_stall) begin
      s_valid <= 1'b0;
      if (i_flush) begin
        f_valid <= 1'b0;
        o_valid <= 1'b0;
      end else begin
        o_valid    <= d_load_valid;
        o_instr    <= d_word;
        o_pc_plus4 <= f_pc + 32'd4;
        f_valid    <= !halt_seen;
        f_pc       <= i_pc;
        if (d_load_valid && (d_word == HALT_WORD)) begin
          halt_seen <= 1'b1;
        end
      end
    end else if (f_valid && !s_valid) begin
      s_data  <= imem.imem_data;
      s_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - scoreboard bench for instr_fetch with random stall/flush stimulus
module tb_instr_fetch;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  typedef struct {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        halt;
    logic        chk;
  } exp_t;

  logic        clk = 1'b0;
  logic        i_reset = 1'b0;
  logic [31:0] i_pc = 32'd0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] o_instr, o_pc_plus4;
  logic        o_valid, o_halt;

  instr_fetch_if imem_bus ();

  instr_fetch #(.HALT_WORD(HALT)) dut (
    .i_clk      (clk),
    .i_reset    (i_reset),
    .i_pc       (i_pc),
    .i_stall    (stall),
    .i_flush    (flush),
    .imem       (imem_bus),
    .o_instr    (o_instr),
    .o_pc_plus4 (o_pc_plus4),
    .o_valid    (o_valid),
    .o_halt     (o_halt)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [64];

  // Synchronous memory that returns garbage whenever it is not enabled.
  always @(posedge clk) begin
    imem_bus.imem_data <= imem_bus.imem_en ? mem[imem_bus.imem_addr[7:2]] : $urandom();
  end

  int          tests = 0;
  int          fails = 0;
  exp_t        sb [$];
  logic [31:0] inflight [$];
  exp_t        cur;
  exp_t        e;
  logic        halted = 1'b0;
  logic        mon_en = 1'b0;
  logic [31:0] pc = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("o_valid", {31'd0, o_valid}, {31'd0, e.valid});
        chk("o_halt", {31'd0, o_halt}, {31'd0, e.halt});
        if (e.valid || e.chk) begin
          chk("o_instr", o_instr, e.instr);
          chk("o_pc_plus4", o_pc_plus4, e.pc4);
        end
      end
      chk("imem_en", {31'd0, imem_bus.imem_en}, {31'd0, !stall && !halted});
      chk("imem_addr", imem_bus.imem_addr, i_pc);
    end
  end

  // One clock: a fetch issued in an enabled cycle reaches IF/ID at the next
  // advancing edge unless that edge (or its own cycle) is a flush, or HALT came first.
  task automatic step(input logic st, input logic fl, input logic [31:0] tgt);
    logic [31:0] p;
    stall = st;
    flush = fl;
    @(posedge clk);
    if (!st) begin
      if (fl) begin
        inflight.delete();
        cur.valid = 1'b0;
        cur.chk   = 1'b0;
      end else begin
        if (inflight.size() != 0 && !halted) begin
          p = inflight.pop_front();
          cur.valid = 1'b1;
          cur.instr = mem[p[7:2]];
          cur.pc4   = p + 32'd4;
          cur.chk   = 1'b1;
          if (cur.instr == HALT) halted = 1'b1;
        end else begin
          cur.valid = 1'b0;
          cur.chk   = 1'b0;
        end
        inflight.delete();
        if (!cur.halt) inflight.push_back(i_pc);
      end
      cur.halt = halted;
    end
    sb.push_back(cur);
    if (!st && !halted) pc = fl ? tgt : pc + 32'd4;
    #2;
    i_pc = pc;
  endtask

  task automatic do_reset(input logic [31:0] new_pc);
    #1;
    i_reset = 1'b0;
    mon_en  = 1'b0;
    sb.delete();
    inflight.delete();
    halted = 1'b0;
    cur = '{valid: 1'b0, instr: 32'd0, pc4: 32'd0, halt: 1'b0, chk: 1'b1};
    #1;
    chk("rst_o_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_o_instr", o_instr, 32'd0);
    chk("rst_o_pc_plus4", o_pc_plus4, 32'd0);
    chk("rst_o_halt", {31'd0, o_halt}, 32'd0);
    chk("rst_imem_en", {31'd0, imem_bus.imem_en}, {31'd0, !stall});
    @(posedge clk);
    #2;
    i_reset = 1'b1;
    stall   = 1'b0;
    flush   = 1'b0;
    pc      = new_pc;
    i_pc    = pc;
    mon_en  = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + i;

    do_reset(32'd0);
    // Straight-line run, then a jump while F=8 and D=4.
    repeat (3) step(1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b1, 32'h40);
    repeat (4) step(1'b0, 1'b0, 32'd0);
    // Stall with the memory returning garbage while disabled.
    repeat (3) step(1'b1, 1'b0, 32'd0);
    repeat (3) step(1'b0, 1'b0, 32'd0);
    // Stall and flush together must leave the flow untouched.
    repeat (2) step(1'b1, 1'b1, 32'h80);
    repeat (3) step(1'b0, 1'b0, 32'd0);
    // PC+4 wraps at the top of the address space.
    step(1'b0, 1'b1, 32'hFFFF_FFFC);
    repeat (4) step(1'b0, 1'b0, 32'd0);

    for (int n = 0; n < 300; n++) begin
      step(($urandom % 5) == 0, ($urandom % 8) == 0,
           (($urandom % 16) == 0) ? 32'hFFFF_FFFC : {24'd0, 6'($urandom_range(0, 63)), 2'b00});
    end

    mem[8] = HALT;
    step(1'b0, 1'b1, 32'h10);
    for (int n = 0; n < 12; n++) step(($urandom % 4) == 0, 1'b0, 32'd0);
    repeat (6) step($urandom % 2, $urandom % 2, 32'h40);
    chk("halt_reached", {31'd0, o_halt}, 32'd1);
    mem[8] = 32'h1000_0008;

    // Reset during a stall with the skid loaded.
    do_reset(32'd0);
    repeat (4) step(1'b0, 1'b0, 32'd0);
    repeat (2) step(1'b1, 1'b0, 32'd0);
    do_reset(32'h30);
    repeat (5) step(1'b0, 1'b0, 32'd0);

    @(negedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
